line_buffer_ntap: RTL and testbench
===================================

# line_buffer_ntap

Parametrised multi-line buffer for the VIP window generators (Sobel, Gaussian, NMS). It stores up to `NUM_TAPS` previous image lines in on-chip RAM and presents the current pixel with the same-column pixels from the previous lines, aligned on one output strobe. It adds frame-aware top-border handling, line counting and overflow detection. Its outputs feed the matrix/window builders directly.

## Interface
- `DATA_W`, 8: pixel width in bits.
- `LINE_MAX`, 1024: maximum pixels per line, which is the RAM depth.
- `ADDR_W`, 10: column address width; must satisfy 2^ADDR_W >= LINE_MAX.
- `NUM_TAPS`, 2: number of stored previous lines, 1..4; one RAM per tap.
- `EDGE_MODE`, 1: top-border policy. 0 = zero fill; 1 = replicate the nearest valid line.

- `clock`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `per_frame_vsync`  in  1  frame sync; its rising edge starts a new frame.
- `per_frame_href`  in  1  line-active flag; low between lines.
- `clken`  in  1  pixel strobe; a pixel is accepted only when `clken & per_frame_href`.
- `shiftin`  in  DATA_W  input pixel.
- `shiftout`  out  DATA_W  current pixel, delayed to align with the taps.
- `taps`  out  NUM_TAPS*DATA_W  slice k holds the pixel from k+1 lines earlier at the same column; slice 0 is in the LSBs.
- `out_valid`  out  1  one-cycle strobe marking valid `shiftout`/`taps`.
- `line_cnt`  out  ADDR_W  number of completed lines in the current frame.
- `ovf`  out  1  sticky flag: a line exceeded `LINE_MAX`.

## Operation
- **Column counter `col`:**
  - Cleared to 0 while `per_frame_href` = 0.
  - Increments on each accepted pixel.
  - Saturates at `LINE_MAX-1`.
- **Stage 0 (accept cycle):** all tap RAMs are read at `col`; `col` and `shiftin` are registered.
- **Stage 1:**
  - RAM outputs are valid.
  - Write cascade at the registered column: RAM0 <- registered `shiftin`; RAMk <- RAM(k-1) read data.
  - Read-before-write to the same address is guaranteed because the read occurred one cycle earlier.
- **Stage 2:** the output registers load. Border masking is applied, then `out_valid` = 1.
- **`lines_seen` counter:**
  - Cleared on a `per_frame_vsync` rising edge.
  - Increments on each `per_frame_href` falling edge that had at least one accepted pixel.
  - Saturates at `NUM_TAPS`.
- **Border masking:** tap k is valid only if `lines_seen > k`, sampled when the pixel is accepted. For invalid taps:
  - EDGE_MODE = 0: output 0.
  - EDGE_MODE = 1: output the highest-index valid tap, or `shiftout` if no tap is valid.
- **RAM contents** are never cleared. Stale data from the previous frame is hidden solely by masking.
- **`line_cnt`:** same increment rule as `lines_seen`, but it does not saturate below 2^ADDR_W-1. It is cleared on a vsync rising edge.
- **Overflow:** an accepted pixel arriving while `col` = `LINE_MAX-1` and a pixel was already written there:
  - sets `ovf`;
  - the pixel still passes to `shiftout`, but RAM writes are suppressed for the rest of the line.
  - `ovf` clears on a vsync rising edge.
- **Simultaneous events:** when a vsync rising edge and an href falling edge occur in the same cycle, the clear wins.

## Timing
- Latency from accept cycle to `out_valid`: exactly 2 cycles, with `shiftout` and `taps` valid in that same cycle.
- Throughput: one pixel per cycle. Back-to-back and gapped `clken` are both supported, and output ordering is preserved.
- Pixels in flight when `per_frame_href` falls still complete and emerge 2 cycles later.
- **Reset:** `shiftout`, `taps`, `out_valid`, `line_cnt`, `ovf`, `col`, `lines_seen` and the pipeline valids all go to 0 immediately.
  - A reset mid-line discards in-flight pixels; no `out_valid` is produced for them.
  - After a reset, all taps are masked until lines are seen again.
- The vsync edge detector is registered, so a clear takes effect 1 cycle after the edge.

## Test plan
- **Line shift, NUM_TAPS = 2, 4-pixel lines:** line0 = 10..13, line1 = 20..23, line2 = 30..33 (EDGE_MODE = 0).
  - Line2 column 1 -> `shiftout` = 31, tap0 = 21, tap1 = 11.
  - Line0 outputs -> taps = 0.
  - `out_valid` exactly 2 cycles after each accept.
- **Replicate border, EDGE_MODE = 1, same stimulus:**
  - Line0 column 2 -> tap0 = tap1 = 12.
  - Line1 column 2 -> tap0 = 12, tap1 = 12.
- **Gapped `clken`** (pattern 1,0,0,1,1,0,1) -> the outputs are the identical sequence to back-to-back input, and the `out_valid` count equals the accepted-pixel count.
- **Frame boundary:** after 3 lines, pulse vsync, then feed new line 50..53 -> taps masked (0 with EDGE_MODE = 0) and `line_cnt` = 1 after that line.
- **Overflow, LINE_MAX = 8:** feed a 10-pixel line -> `ovf` = 1 from the 9th accept. The next line's tap0 at columns 0..7 equals the first 8 pixels. `ovf` holds until vsync.
- **Reset mid-line** after 2 accepts -> all outputs 0 next cycle, no `out_valid` pulses, `line_cnt` = 0.

Source files
------------

// File: rtl/line_buffer_ntap_if.sv
// Pixel stream and tap outputs of the multi-line buffer, grouped as one bus.
// The source (video front end) drives the master side; the line buffer is the slave.
interface line_buffer_ntap_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int NUM_TAPS = 2
);
  logic                         per_frame_vsync;
  logic                         per_frame_href;
  logic                         clken;
  logic [DATA_W-1:0]            shiftin;
  logic [DATA_W-1:0]            shiftout;
  logic [NUM_TAPS*DATA_W-1:0]   taps;
  logic                         out_valid;
  logic [ADDR_W-1:0]            line_cnt;
  logic                         ovf;

  modport master (
    output per_frame_vsync, per_frame_href, clken, shiftin,
    input  shiftout, taps, out_valid, line_cnt, ovf
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, clken, shiftin,
    output shiftout, taps, out_valid, line_cnt, ovf
  );
endinterface

// File: rtl/line_buffer_ntap.sv
// NUM_TAPS-line buffer: presents the current pixel with same-column pixels of the
// previous lines, 2-cycle latency, with frame-aware top-border masking and overflow detect.
module line_buffer_ntap #(
  parameter int DATA_W    = 8,
  parameter int LINE_MAX  = 1024,
  parameter int ADDR_W    = 10,
  parameter int NUM_TAPS  = 2,
  parameter int EDGE_MODE = 1
) (
  input  logic               clock,
  input  logic               rst_n,
  line_buffer_ntap_if.slave  bus
);

  localparam int                LS_W     = $clog2(NUM_TAPS + 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_MAX - 1);
  localparam logic [LS_W-1:0]   LS_MAX   = LS_W'(NUM_TAPS);

  logic [DATA_W-1:0] ram [NUM_TAPS][LINE_MAX];
  logic [DATA_W-1:0] rd_q [NUM_TAPS];
  logic [DATA_W-1:0] rd_d [NUM_TAPS];

  logic [ADDR_W-1:0]          col_q, col_d;
  logic                       last_wr_q, last_wr_d;
  logic                       inhibit_q, inhibit_d;
  logic                       had_px_q, had_px_d;
  logic                       href_q, href_d;
  logic                       vsync_q, vsync_d;
  logic [LS_W-1:0]            ls_q, ls_d;
  logic [ADDR_W-1:0]          line_cnt_q, line_cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       s1_vld_q, s1_vld_d;
  logic                       s1_we_q, s1_we_d;
  logic [ADDR_W-1:0]          s1_col_q, s1_col_d;
  logic [DATA_W-1:0]          s1_pix_q, s1_pix_d;
  logic [LS_W-1:0]            s1_ls_q, s1_ls_d;
  logic                       out_vld_q, out_vld_d;
  logic [DATA_W-1:0]          shiftout_q, shiftout_d;
  logic [NUM_TAPS*DATA_W-1:0] taps_q, taps_d;

  logic accept, at_last, ovf_now, vs_rise, line_done;
  logic [DATA_W-1:0] tap_v;

  always_comb begin
    accept    = bus.clken & bus.per_frame_href;
    at_last   = (col_q == COL_LAST);
    ovf_now   = accept & at_last & last_wr_q;
    vs_rise   = bus.per_frame_vsync & ~vsync_q;
    line_done = href_q & ~bus.per_frame_href & had_px_q;

    href_d  = bus.per_frame_href;
    vsync_d = bus.per_frame_vsync;

    col_d     = col_q;
    last_wr_d = last_wr_q;
    inhibit_d = inhibit_q;
    had_px_d  = had_px_q;
    if (!bus.per_frame_href) begin
      col_d     = '0;
      last_wr_d = 1'b0;
      inhibit_d = 1'b0;
      had_px_d  = 1'b0;
    end else if (accept) begin
      had_px_d = 1'b1;
      if (!at_last) col_d = col_q + 1'b1;
      else          last_wr_d = 1'b1;
      if (ovf_now)  inhibit_d = 1'b1;
    end

    // Frame clear has priority over a line completing in the same cycle.
    ls_d       = ls_q;
    line_cnt_d = line_cnt_q;
    ovf_d      = ovf_q;
    if (vs_rise) begin
      ls_d       = '0;
      line_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (line_done && ls_q != LS_MAX) ls_d = ls_q + 1'b1;
      if (line_done && line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
      if (ovf_now) ovf_d = 1'b1;
    end

    s1_vld_d = accept;
    s1_we_d  = accept & ~ovf_now & ~inhibit_q;
    s1_col_d = accept ? col_q    : s1_col_q;
    s1_pix_d = accept ? bus.shiftin : s1_pix_q;
    s1_ls_d  = accept ? ls_q     : s1_ls_q;
    for (int unsigned k = 0; k < NUM_TAPS; k++)
      rd_d[k] = accept ? ram[k][col_q] : rd_q[k];

    out_vld_d  = s1_vld_q;
    shiftout_d = shiftout_q;
    taps_d     = taps_q;
    tap_v      = '0;
    if (s1_vld_q) begin
      shiftout_d = s1_pix_q;
      // Taps not yet filled this frame read as zero or the deepest filled line.
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        if (32'(s1_ls_q) > k)      tap_v = rd_q[k];
        else if (EDGE_MODE == 0)   tap_v = '0;
        else if (s1_ls_q == '0)    tap_v = s1_pix_q;
        else                       tap_v = rd_q[s1_ls_q - 1'b1];
        taps_d[k*DATA_W +: DATA_W] = tap_v;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      last_wr_q  <= 1'b0;
      inhibit_q  <= 1'b0;
      had_px_q   <= 1'b0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      ls_q       <= '0;
      line_cnt_q <= '0;
      ovf_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_col_q   <= '0;
      s1_pix_q   <= '0;
      s1_ls_q    <= '0;
      out_vld_q  <= 1'b0;
      shiftout_q <= '0;
      taps_q     <= '0;
    end else begin
      col_q      <= col_d;
      last_wr_q  <= last_wr_d;
      inhibit_q  <= inhibit_d;
      had_px_q   <= had_px_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      ls_q       <= ls_d;
      line_cnt_q <= line_cnt_d;
      ovf_q      <= ovf_d;
      s1_vld_q   <= s1_vld_d;
      s1_we_q    <= s1_we_d;
      s1_col_q   <= s1_col_d;
      s1_pix_q   <= s1_pix_d;
      s1_ls_q    <= s1_ls_d;
      out_vld_q  <= out_vld_d;
      shiftout_q <= shiftout_d;
      taps_q     <= taps_d;
    end
  end

  // The cascade writes the column read one cycle earlier, so each tap moves down a line.
  always_ff @(posedge clock) begin
    rd_q <= rd_d;
    if (s1_we_q) begin
      ram[0][s1_col_q] <= s1_pix_q;
      for (int unsigned k = 1; k < NUM_TAPS; k++)
        ram[k][s1_col_q] <= rd_q[k-1];
    end
  end

  assign bus.shiftout  = shiftout_q;
  assign bus.taps      = taps_q;
  assign bus.out_valid = out_vld_q;
  assign bus.line_cnt  = line_cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_line_buffer_ntap.sv
// Scoreboard bench: two buffers (zero-fill and replicate border) share one stimulus stream;
// a line-level reference supplies expected words, a negedge monitor pops and compares.
module tb_line_buffer_ntap;
  localparam int DW = 8;
  localparam int LM = 8;
  localparam int AW = 4;
  localparam int NT = 2;

  typedef logic [DW*(NT+1)-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_buffer_ntap_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_TAPS(NT)) ifa ();
  line_buffer_ntap_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_TAPS(NT)) ifb ();

  line_buffer_ntap #(.DATA_W(DW), .LINE_MAX(LM), .ADDR_W(AW), .NUM_TAPS(NT), .EDGE_MODE(0))
    dut_a (.clock(clk), .rst_n(rst_n), .bus(ifa.slave));
  line_buffer_ntap #(.DATA_W(DW), .LINE_MAX(LM), .ADDR_W(AW), .NUM_TAPS(NT), .EDGE_MODE(1))
    dut_b (.clock(clk), .rst_n(rst_n), .bus(ifb.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop_a  = 0;
  int n_pop_b  = 0;
  word_t qa[$], qb[$];
  word_t log_a[$], log_b[$];

  logic [DW-1:0] hist [NT][LM];
  logic [DW-1:0] cur [LM];
  int idx = 0;
  int ls  = 0;
  int lc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    if (ifa.out_valid) begin
      if (qa.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_out", {ifa.taps, ifa.shiftout}, e);
        log_a.push_back({ifa.taps, ifa.shiftout});
        n_pop_a++;
      end
    end
    if (ifb.out_valid) begin
      if (qb.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_out", {ifb.taps, ifb.shiftout}, e);
        log_b.push_back({ifb.taps, ifb.shiftout});
        n_pop_b++;
      end
    end
  end

  function automatic word_t expw(input int mode, input logic [DW-1:0] pix, input int c);
    word_t w;
    w = '0;
    w[DW-1:0] = pix;
    for (int k = 0; k < NT; k++) begin
      logic [DW-1:0] t;
      if (ls > k)        t = hist[k][c];
      else if (mode == 0) t = '0;
      else if (ls > 0)   t = hist[ls-1][c];
      else               t = pix;
      w[(k+1)*DW +: DW] = t;
    end
    return w;
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic ce, input logic [DW-1:0] d);
    ifa.per_frame_vsync = vs; ifa.per_frame_href = hr; ifa.clken = ce; ifa.shiftin = d;
    ifb.per_frame_vsync = vs; ifb.per_frame_href = hr; ifb.clken = ce; ifb.shiftin = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] pix);
    int c;
    c = (idx < LM) ? idx : LM - 1;
    qa.push_back(expw(0, pix, c));
    qb.push_back(expw(1, pix, c));
    n_push++;
    if (idx < LM) cur[idx] = pix;
    idx++;
    drive(1'b0, 1'b1, 1'b1, pix);
    tick(1);
  endtask

  task automatic gap();
    drive(1'b0, 1'b1, 1'b0, '0);
    tick(1);
  endtask

  task automatic end_line();
    int nw;
    if (idx > 0) begin
      nw = (idx < LM) ? idx : LM;
      for (int c = 0; c < nw; c++) begin
        for (int k = NT - 1; k > 0; k--) hist[k][c] = hist[k-1][c];
        hist[0][c] = cur[c];
      end
      if (ls < NT) ls++;
      lc++;
    end
    idx = 0;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick(4);
  endtask

  task automatic line(input int base, input int n);
    for (int i = 0; i < n; i++) send(DW'(base + i));
    end_line();
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 1'b0, '0);
    tick(2);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick(2);
    ls = 0;
    lc = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},    {31'd0, ifa.out_valid | ifb.out_valid}, 32'd0);
    check({tag, "_shiftout"}, {24'd0, ifa.shiftout | ifb.shiftout}, 32'd0);
    check({tag, "_taps"},     {16'd0, ifa.taps | ifb.taps}, 32'd0);
    check({tag, "_line_cnt"}, {28'd0, ifa.line_cnt | ifb.line_cnt}, 32'd0);
    check({tag, "_ovf"},      {31'd0, ifa.ovf | ifb.ovf}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NT; k++)
      for (int c = 0; c < LM; c++) hist[k][c] = '0;
    drive(1'b0, 1'b0, 1'b0, '0);
    tick(3);
    check_idle("reset");
    rst_n = 1'b1;
    tick(2);

    vsync_pulse();
    line(10, 4);
    line(20, 4);
    line(30, 4);
    check("a_line_cnt_3", {28'd0, ifa.line_cnt}, 32'(lc));
    check("b_line_cnt_3", {28'd0, ifb.line_cnt}, 32'd3);
    check("a_l2c1_hand", log_a[9], {8'd11, 8'd21, 8'd31});
    check("a_l0c2_hand", log_a[2], {8'd0, 8'd0, 8'd12});
    check("b_l0c2_hand", log_b[2], {8'd12, 8'd12, 8'd12});
    check("b_l1c2_hand", log_b[6], {8'd12, 8'd12, 8'd22});

    // Gapped strobe pattern 1,0,0,1,1,0,1
    send(8'd40); gap(); gap(); send(8'd41); send(8'd42); gap(); send(8'd43);
    end_line();
    check("a_l3c1_hand", log_a[13], {8'd21, 8'd31, 8'd41});
    check("a_line_cnt_4", {28'd0, ifa.line_cnt}, 32'd4);

    vsync_pulse();
    line(50, 4);
    check("a_frame_line_cnt", {28'd0, ifa.line_cnt}, 32'd1);
    check("a_frame_masked", log_a[17], {8'd0, 8'd0, 8'd51});

    vsync_pulse();
    for (int i = 0; i < 8; i++) send(DW'(60 + i));
    check("a_ovf_before", {31'd0, ifa.ovf}, 32'd0);
    send(8'd68);
    check("a_ovf_9th", {31'd0, ifa.ovf}, 32'd1);
    check("b_ovf_9th", {31'd0, ifb.ovf}, 32'd1);
    send(8'd69);
    end_line();
    line(70, 8);
    check("a_ovf_hold", {31'd0, ifa.ovf}, 32'd1);
    check("a_ovf_next_c7", log_a[log_a.size()-1], {8'd0, 8'd67, 8'd77});
    check("b_ovf_next_c7", log_b[log_b.size()-1], {8'd67, 8'd67, 8'd77});
    check("a_line_cnt_2", {28'd0, ifa.line_cnt}, 32'd2);
    vsync_pulse();
    check("a_ovf_cleared", {31'd0, ifa.ovf}, 32'd0);
    check("a_line_cnt_clr", {28'd0, ifa.line_cnt}, 32'd0);

    line(90, 4);
    send(8'd80);
    send(8'd81);
    rst_n = 1'b0;
    n_push = n_push - qa.size();
    qa.delete();
    qb.delete();
    idx = 0; ls = 0; lc = 0;
    #1;
    check_idle("midreset");
    tick(3);
    drive(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    tick(4);
    check_idle("after_reset");

    check("a_valid_count", 32'(n_pop_a), 32'(n_push));
    check("b_valid_count", 32'(n_pop_b), 32'(n_push));
    check("a_queue_empty", 32'(qa.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
